vfr_capture_ctrl: RTL and testbench

- Synthesizable sequencer placed in front of the scaler2 input or a frame-capture sink on the parallel video bus (di/de/hs/vs).
- On command, it arms, waits for a frame boundary and passes a programmed number of whole frames downstream; outside that window it blanks de.
- Measures per-frame geometry (active pixels per line, active lines per frame) and flags geometry errors.

---
 rtl/vfr_capture_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vfr_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vfr_capture_ctrl.sv
// Capture window sequencer for the parallel video bus: arms on start, passes whole frames, measures geometry.
// Optional watchdog is compiled in with `define VFR_CAPTURE_CTRL_WDOG_EN.
`timescale 1ns/1ps
module vfr_capture_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned XSIZE_W    = 12,
   parameter int unsigned YSIZE_W    = 12,
   parameter int unsigned FRCNT_W    = 8,
   parameter int unsigned WDOG_W     = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [FRCNT_W-1:0]    frcnt_i,
   input  logic [DATA_WIDTH-1:0] di_i,
   input  logic                  de_i,
   input  logic                  hs_i,
   input  logic                  vs_i,
   output logic [DATA_WIDTH-1:0] do_o,
   output logic                  de_o,
   output logic                  hs_o,
   output logic                  vs_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [XSIZE_W-1:0]    xsize_o,
   output logic [YSIZE_W-1:0]    ysize_o,
   output logic [FRCNT_W-1:0]    frdone_o,
   output logic                  err_o,
   output logic                  to_o
);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t               state;
   logic                 vs_d, hs_d;
   logic [XSIZE_W-1:0]   xcnt, lref, fref_x, lref_n;
   logic [YSIZE_W-1:0]   ycnt, fref_y, ycnt_n;
   logic [FRCNT_W-1:0]   frcnt, frdone_n;
   logic                 fref_vld, stop_pend;
   logic                 frame_start, frame_end, line_end, close_line;
   logic                 line_err, frame_err, x_sat, frame_hit, wdog_exp;

   assign busy_o = (state != IDLE);

   // A line still open when vs rises is closed in the same cycle, so the
   // frame-end results use the post-close geometry (lref_n / ycnt_n).
   always_comb begin
      frame_start = vs_d & ~vs_i;
      frame_end   = ~vs_d & vs_i;
      line_end    = ~hs_d & hs_i;
      close_line  = (xcnt != '0) && (line_end || frame_end);
      lref_n      = lref;
      ycnt_n      = ycnt;
      line_err    = 1'b0;
      if (close_line) begin
         if (ycnt == '0)
            lref_n = xcnt;
         else if (xcnt != lref)
            line_err = 1'b1;
         if (ycnt != '1)
            ycnt_n = ycnt + YSIZE_W'(1);
      end
      frame_err = fref_vld && ((lref_n != fref_x) || (ycnt_n != fref_y));
      frdone_n  = frdone_o + FRCNT_W'(1);
      x_sat     = de_i && (xcnt == '1);
      frame_hit = (frcnt != '0) && (frdone_n == frcnt);
   end

`ifdef VFR_CAPTURE_CTRL_WDOG_EN
   logic [WDOG_W-1:0] wdog;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wdog <= '0;
      else if (state == IDLE || frame_start || frame_end)
         wdog <= '0;
      else
         wdog <= wdog + WDOG_W'(1);
   end

   assign wdog_exp = (state != IDLE) && (wdog == '1);
`else
   assign wdog_exp = 1'b0 & (WDOG_W == 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         vs_d      <= 1'b0;
         hs_d      <= 1'b0;
         do_o      <= '0;
         de_o      <= 1'b0;
         hs_o      <= 1'b0;
         vs_o      <= 1'b0;
         done_o    <= 1'b0;
         xsize_o   <= '0;
         ysize_o   <= '0;
         frdone_o  <= '0;
         err_o     <= 1'b0;
         to_o      <= 1'b0;
         xcnt      <= '0;
         ycnt      <= '0;
         lref      <= '0;
         fref_x    <= '0;
         fref_y    <= '0;
         fref_vld  <= 1'b0;
         frcnt     <= '0;
         stop_pend <= 1'b0;
      end else begin
         vs_d   <= vs_i;
         hs_d   <= hs_i;
         do_o   <= di_i;
         hs_o   <= hs_i;
         vs_o   <= vs_i;
         de_o   <= de_i && (state == RUN);
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state     <= ARM;
                  frcnt     <= frcnt_i;
                  frdone_o  <= '0;
                  err_o     <= 1'b0;
                  to_o      <= 1'b0;
                  lref      <= '0;
                  fref_x    <= '0;
                  fref_y    <= '0;
                  fref_vld  <= 1'b0;
                  stop_pend <= 1'b0;
                  xcnt      <= '0;
                  ycnt      <= '0;
               end
            end
            ARM: begin
               if (stop_i)
                  state <= IDLE;
               else if (wdog_exp) begin
                  to_o  <= 1'b1;
                  state <= IDLE;
               end else if (frame_start)
                  state <= RUN;
            end
            RUN: begin
               if (stop_i)
                  stop_pend <= 1'b1;
               if (x_sat)
                  err_o <= 1'b1;
               if (close_line || frame_end)
                  xcnt <= '0;
               else if (de_i && xcnt != '1)
                  xcnt <= xcnt + XSIZE_W'(1);
               if (close_line) begin
                  lref <= lref_n;
                  ycnt <= ycnt_n;
                  if (line_err)
                     err_o <= 1'b1;
               end
               if (frame_end) begin
                  xsize_o  <= lref_n;
                  ysize_o  <= ycnt_n;
                  frdone_o <= frdone_n;
                  ycnt     <= '0;
                  if (!fref_vld) begin
                     fref_vld <= 1'b1;
                     fref_x   <= lref_n;
                     fref_y   <= ycnt_n;
                  end else if (frame_err)
                     err_o <= 1'b1;
                  if (frame_hit) begin
                     state  <= IDLE;
                     done_o <= 1'b1;
                  end else if (stop_pend || stop_i)
                     state <= IDLE;
               end
               if (wdog_exp) begin
                  to_o   <= 1'b1;
                  state  <= IDLE;
                  done_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vfr_capture_ctrl.sv
// Bench for vfr_capture_ctrl: synthetic 16x4 video source, per-cycle video/done scoreboard,
// table of capture scenarios plus hand sequences for ARM/stop races, async reset and the watchdog.
`timescale 1ns/1ps
module tb_vfr_capture_ctrl;
`ifdef VFR_CAPTURE_CTRL_WDOG_EN
   localparam int unsigned WDOG_TB = 8;
`else
   localparam int unsigned WDOG_TB = 24;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0, stop_i = 1'b0;
   logic [7:0]  frcnt_i = '0;
   logic [7:0]  di_i = '0;
   logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b1;
   logic [7:0]  do_o;
   logic        de_o, hs_o, vs_o, busy_o, done_o, err_o, to_o;
   logic [11:0] xsize_o, ysize_o;
   logic [7:0]  frdone_o;

   vfr_capture_ctrl #(
      .DATA_WIDTH(8), .XSIZE_W(12), .YSIZE_W(12), .FRCNT_W(8), .WDOG_W(WDOG_TB)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .frcnt_i(frcnt_i),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
      .busy_o(busy_o), .done_o(done_o), .xsize_o(xsize_o), .ysize_o(ysize_o),
      .frdone_o(frdone_o), .err_o(err_o), .to_o(to_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       de;
      logic       hs;
      logic       vs;
      logic       done;
   } vid_t;

   typedef struct {
      vid_t v;
      int   cyc;
   } sb_t;

   typedef struct {
      logic [7:0]  frcnt;
      int          nfr;
      int          stop_at;
      int          short_at;
      logic [7:0]  exp_frdone;
      logic [11:0] exp_x;
      logic [11:0] exp_y;
      logic        exp_err;
   } scn_t;

   sb_t  sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Entries become comparable once the DUT has sampled them on a later edge.
   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         sb_t  e;
         vid_t act;
         e   = sbq.pop_front();
         act = {do_o, de_o, hs_o, vs_o, done_o};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL video cyc %0d actual d=%h de=%b hs=%b vs=%b done=%b required d=%h de=%b hs=%b vs=%b done=%b",
                     e.cyc, act.d, act.de, act.hs, act.vs, act.done,
                     e.v.d, e.v.de, e.v.hs, e.v.vs, e.v.done);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic [7:0] d, input logic de, input logic hs, input logic vs,
                      input logic st, input logic sp, input logic pass, input logic dn);
      sb_t e;
      @(posedge clk);
      #1;
      di_i = d; de_i = de; hs_i = hs; vs_i = vs; start_i = st; stop_i = sp;
      e.v   = {d, de & pass, hs, vs, dn};
      e.cyc = cyc;
      sbq.push_back(e);
   endtask

   // 20-cycle line: hs high for 4 cycles of hblank, then npix active pixels.
   task automatic line(input logic vs, input int npix, input logic pass,
                       input int st_c, input int sp_c, input int dn_c);
      for (int c = 0; c < 20; c++) begin
         logic pix;
         pix = !vs && (c >= 4) && (c < 4 + npix);
         drv(8'($urandom), pix, c < 4, vs, c == st_c, c == sp_c, pass, c == dn_c);
      end
   endtask

   // Two vblank lines then four active lines; vs rises at the next vblank (frame end).
   task automatic frame(input logic pass, input int short_ln, input int st_ln, input int st_c,
                        input int sp_ln, input int sp_c, input logic dn_prev);
      line(1'b1, 0, pass, -1, -1, dn_prev ? 0 : -1);
      line(1'b1, 0, pass, -1, -1, -1);
      for (int l = 0; l < 4; l++)
         line(1'b0, (l == short_ln) ? 15 : 16, pass,
              (l == st_ln) ? st_c : -1, (l == sp_ln) ? sp_c : -1, -1);
   endtask

   task automatic vblank_end(input logic dn);
      line(1'b1, 0, 1'b0, -1, -1, dn ? 0 : -1);
      line(1'b1, 0, 1'b0, -1, -1, -1);
   endtask

   task automatic idle(input int n, input logic st, input logic vs);
      for (int i = 0; i < n; i++)
         drv(8'h00, 1'b0, 1'b0, vs, st && (i == 0), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic all_zero(input string name);
      chk(name, {do_o, de_o, hs_o, vs_o, busy_o, done_o, xsize_o, ysize_o, frdone_o, err_o, to_o}, 64'd0);
   endtask

   scn_t tbl[5];

   initial begin
      tbl[0] = '{frcnt: 8'd2, nfr: 3, stop_at: -1, short_at: -1, exp_frdone: 8'd2, exp_x: 12'd16, exp_y: 12'd4, exp_err: 1'b0};
      tbl[1] = '{frcnt: 8'd0, nfr: 4, stop_at:  2, short_at: -1, exp_frdone: 8'd3, exp_x: 12'd16, exp_y: 12'd4, exp_err: 1'b0};
      tbl[2] = '{frcnt: 8'd3, nfr: 3, stop_at: -1, short_at:  1, exp_frdone: 8'd3, exp_x: 12'd16, exp_y: 12'd4, exp_err: 1'b1};
      tbl[3] = '{frcnt: 8'd1, nfr: 2, stop_at: -1, short_at: -1, exp_frdone: 8'd1, exp_x: 12'd16, exp_y: 12'd4, exp_err: 1'b0};
      tbl[4] = '{frcnt: 8'd5, nfr: 3, stop_at:  0, short_at: -1, exp_frdone: 8'd1, exp_x: 12'd16, exp_y: 12'd4, exp_err: 1'b0};

      #3;
      all_zero("reset_state");
      #9 rst = 1'b0;

      for (int s = 0; s < 5; s++) begin
         int fc;
         fc = int'(tbl[s].frcnt);
         frcnt_i = tbl[s].frcnt;
         idle(3, 1'b1, 1'b1);
         chk($sformatf("busy_arm_%0d", s), busy_o, 1);
         for (int i = 0; i < tbl[s].nfr; i++) begin
            logic pass, dn_prev;
            pass    = (fc == 0 || i < fc) && (tbl[s].stop_at < 0 || i <= tbl[s].stop_at);
            dn_prev = (i > 0) && (fc != 0) && (i - 1 == fc - 1);
            frame(pass, (i == tbl[s].short_at) ? 2 : -1, -1, -1,
                  (i == tbl[s].stop_at) ? 1 : -1, 7, dn_prev);
         end
         vblank_end(fc != 0 && tbl[s].nfr == fc);
         @(posedge clk);
         #2;
         chk($sformatf("frdone_%0d", s), frdone_o, tbl[s].exp_frdone);
         chk($sformatf("xsize_%0d", s), xsize_o, tbl[s].exp_x);
         chk($sformatf("ysize_%0d", s), ysize_o, tbl[s].exp_y);
         chk($sformatf("err_%0d", s), err_o, tbl[s].exp_err);
         chk($sformatf("busy_end_%0d", s), busy_o, 0);
         chk($sformatf("to_%0d", s), to_o, 0);
      end

      // Start accepted mid-frame: the partial frame is blanked, the next whole frame passes.
      frcnt_i = 8'd1;
      frame(1'b0, -1, 1, 10, -1, -1, 1'b0);
      frame(1'b1, -1, -1, -1, -1, -1, 1'b0);
      vblank_end(1'b1);
      @(posedge clk);
      #2;
      chk("mid_frdone", frdone_o, 1);
      chk("mid_xsize", xsize_o, 16);
      chk("mid_ysize", ysize_o, 4);
      chk("mid_busy", busy_o, 0);

      // Stop coincident with the frame-start edge while armed.
      frcnt_i = 8'd0;
      idle(3, 1'b1, 1'b1);
      chk("race_busy_arm", busy_o, 1);
      frame(1'b0, -1, -1, -1, 0, 0, 1'b0);
      frame(1'b0, -1, -1, -1, -1, -1, 1'b0);
      vblank_end(1'b0);
      @(posedge clk);
      #2;
      chk("race_busy", busy_o, 0);
      chk("race_frdone", frdone_o, 0);

      // Asynchronous reset in the middle of an active line.
      idle(3, 1'b1, 1'b1);
      frame(1'b1, -1, -1, -1, -1, -1, 1'b0);
      line(1'b1, 0, 1'b1, -1, -1, -1);
      line(1'b1, 0, 1'b1, -1, -1, -1);
      for (int c = 0; c < 10; c++)
         drv(8'($urandom), c >= 4, c < 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #6;
      chk("pre_rst_de", de_o, 1);
      chk("pre_rst_frdone", frdone_o, 1);
      chk("pre_rst_busy", busy_o, 1);
      rst = 1'b1;
      #1;
      all_zero("async_rst");
      #5 rst = 1'b0;
      idle(4, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_frdone", frdone_o, 0);

`ifdef VFR_CAPTURE_CTRL_WDOG_EN
      begin
         int first;
         first = -1;
         idle(3, 1'b0, 1'b0);
         for (int n = 0; n < 300; n++) begin
            drv(8'h00, 1'b0, 1'b0, 1'b0, n == 0, 1'b0, 1'b0, 1'b0);
            if (first < 0 && to_o) first = n;
         end
         @(posedge clk);
         #2;
         chk("wdog_to", to_o, 1);
         chk("wdog_busy", busy_o, 0);
         chk("wdog_time_window", (first >= 250 && first <= 265), 1);
      end
`endif

      @(posedge clk);
      #6;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
